// File: rtl/tgroup_scheduler.sv
// tgroup_scheduler
//   Accepts kernel-launch requests from NumRequesters requesters (round-robin),
//   gives each a thread-group ID, launches groups in ID order to the thread
//   dispatcher, counts thread-block completions per group and reports each
//   finished group with its ID and originating requester.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o     per-requester launch handshake (ready one-hot)
//   req_pc_i, req_dp_addr_i,
//   req_number_of_tblocks_i       flattened per-requester launch payload
//   accept_tgroup_id_o            ID handed to this cycle's granted requester
//   disp_ready_i / disp_start_o   launch handshake towards thread_dispatcher
//   disp_*_o                      launch payload (zero when nothing is pending)
//   tblock_done_i,
//   tblock_done_tgroup_id_i       one finished thread block and its group
//   done_valid_o / done_ready_i   completed-group report handshake
//   done_tgroup_id_o,
//   done_requester_o              completed group ID and its requester
//   error_o                       sticky: completion for a non-running group
//                                 or one with no blocks outstanding
module tgroup_scheduler #(
   parameter int unsigned NumRequesters = 2,
   parameter int unsigned Depth         = 4,
   parameter int unsigned PcWidth       = 16,
   parameter int unsigned AddressWidth  = 32,
   parameter int unsigned TblockIdxBits = 8,
   parameter int unsigned TgroupIdBits  = 8,
   localparam int unsigned ReqIdxBits   = (NumRequesters > 1) ? $clog2(NumRequesters) : 1
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic [NumRequesters-1:0]                req_valid_i,
   output logic [NumRequesters-1:0]                req_ready_o,
   input  logic [NumRequesters*PcWidth-1:0]        req_pc_i,
   input  logic [NumRequesters*AddressWidth-1:0]   req_dp_addr_i,
   input  logic [NumRequesters*TblockIdxBits-1:0]  req_number_of_tblocks_i,
   output logic [TgroupIdBits-1:0]                 accept_tgroup_id_o,
   input  logic                                    disp_ready_i,
   output logic                                    disp_start_o,
   output logic [PcWidth-1:0]                      disp_pc_o,
   output logic [AddressWidth-1:0]                 disp_dp_addr_o,
   output logic [TblockIdxBits-1:0]                disp_number_of_tblocks_o,
   output logic [TgroupIdBits-1:0]                 disp_tgroup_id_o,
   input  logic                                    tblock_done_i,
   input  logic [TgroupIdBits-1:0]                 tblock_done_tgroup_id_i,
   output logic                                    done_valid_o,
   input  logic                                    done_ready_i,
   output logic [TgroupIdBits-1:0]                 done_tgroup_id_o,
   output logic [ReqIdxBits-1:0]                   done_requester_o,
   output logic                                    error_o
);

   localparam int unsigned SlotW = (Depth > 1) ? $clog2(Depth) : 1;

   typedef enum logic [1:0] {
      SLOT_FREE,
      SLOT_PENDING,
      SLOT_RUNNING
   } slot_state_e;

   slot_state_e              state_q [Depth];
   slot_state_e              state_d [Depth];
   logic [PcWidth-1:0]       pc_q    [Depth];
   logic [PcWidth-1:0]       pc_d    [Depth];
   logic [AddressWidth-1:0]  dp_q    [Depth];
   logic [AddressWidth-1:0]  dp_d    [Depth];
   logic [TblockIdxBits-1:0] cnt_q   [Depth];
   logic [TblockIdxBits-1:0] cnt_d   [Depth];
   logic [TblockIdxBits-1:0] rem_q   [Depth];
   logic [TblockIdxBits-1:0] rem_d   [Depth];
   logic [TgroupIdBits-1:0]  id_q    [Depth];
   logic [TgroupIdBits-1:0]  id_d    [Depth];
   logic [ReqIdxBits-1:0]    owner_q [Depth];
   logic [ReqIdxBits-1:0]    owner_d [Depth];

   logic [TgroupIdBits-1:0]  next_id_q, next_id_d;
   logic [TgroupIdBits-1:0]  launch_id_q, launch_id_d;
   logic [ReqIdxBits-1:0]    rr_q, rr_d;
   logic                     error_q, error_d;

   logic [SlotW-1:0]         acc_slot, launch_slot, cpl_slot, done_slot;
   logic                     grant_valid, done_found;
   logic [ReqIdxBits-1:0]    grant_idx, cand;

   // Group IDs map onto table slots by their low bits (Depth is a power of two).
   function automatic logic [SlotW-1:0] slot_of(input logic [TgroupIdBits-1:0] id);
      return (Depth > 1) ? id[SlotW-1:0] : '0;
   endfunction

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      dp_d        = dp_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      id_d        = id_q;
      owner_d     = owner_q;
      next_id_d   = next_id_q;
      launch_id_d = launch_id_q;
      rr_d        = rr_q;
      error_d     = error_q;

      acc_slot    = slot_of(next_id_q);
      launch_slot = slot_of(launch_id_q);
      cpl_slot    = slot_of(tblock_done_tgroup_id_i);

      req_ready_o              = '0;
      accept_tgroup_id_o       = next_id_q;
      disp_start_o             = 1'b0;
      disp_pc_o                = '0;
      disp_dp_addr_o           = '0;
      disp_number_of_tblocks_o = '0;
      disp_tgroup_id_o         = '0;
      done_valid_o             = 1'b0;
      done_tgroup_id_o         = '0;
      done_requester_o         = '0;
      error_o                  = error_q;

      // Round-robin grant, only when the slot for the next ID is free.
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      if (state_q[acc_slot] == SLOT_FREE) begin
         for (int unsigned i = 0; i < NumRequesters; i++) begin
            cand = ReqIdxBits'((32'(rr_q) + i) % NumRequesters);
            if (!grant_valid && req_valid_i[cand]) begin
               grant_valid = 1'b1;
               grant_idx   = cand;
            end
         end
      end

      if (grant_valid) begin
         req_ready_o[grant_idx] = 1'b1;
         state_d[acc_slot] = SLOT_PENDING;
         pc_d[acc_slot]    = req_pc_i[grant_idx*PcWidth +: PcWidth];
         dp_d[acc_slot]    = req_dp_addr_i[grant_idx*AddressWidth +: AddressWidth];
         cnt_d[acc_slot]   = req_number_of_tblocks_i[grant_idx*TblockIdxBits +: TblockIdxBits];
         rem_d[acc_slot]   = req_number_of_tblocks_i[grant_idx*TblockIdxBits +: TblockIdxBits];
         id_d[acc_slot]    = next_id_q;
         owner_d[acc_slot] = grant_idx;
         next_id_d         = next_id_q + 1'b1;
         if (32'(grant_idx) >= NumRequesters - 1)
            rr_d = '0;
         else
            rr_d = grant_idx + 1'b1;
      end

      // Launch strictly in ID order.
      if (state_q[launch_slot] == SLOT_PENDING) begin
         disp_start_o             = 1'b1;
         disp_pc_o                = pc_q[launch_slot];
         disp_dp_addr_o           = dp_q[launch_slot];
         disp_number_of_tblocks_o = cnt_q[launch_slot];
         disp_tgroup_id_o         = id_q[launch_slot];
         if (disp_ready_i) begin
            state_d[launch_slot] = SLOT_RUNNING;
            launch_id_d          = launch_id_q + 1'b1;
         end
      end

      if (tblock_done_i) begin
         if (state_q[cpl_slot] == SLOT_RUNNING && rem_q[cpl_slot] != '0)
            rem_d[cpl_slot] = rem_q[cpl_slot] - 1'b1;
         else
            error_d = 1'b1;
      end

      // Report the lowest-index finished slot.
      done_found = 1'b0;
      done_slot  = '0;
      for (int unsigned s = 0; s < Depth; s++) begin
         if (!done_found && state_q[s] == SLOT_RUNNING && rem_q[s] == '0) begin
            done_found = 1'b1;
            done_slot  = SlotW'(s);
         end
      end
      if (done_found) begin
         done_valid_o     = 1'b1;
         done_tgroup_id_o = id_q[done_slot];
         done_requester_o = owner_q[done_slot];
         if (done_ready_i)
            state_d[done_slot] = SLOT_FREE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned s = 0; s < Depth; s++) begin
            state_q[s] <= SLOT_FREE;
            pc_q[s]    <= '0;
            dp_q[s]    <= '0;
            cnt_q[s]   <= '0;
            rem_q[s]   <= '0;
            id_q[s]    <= '0;
            owner_q[s] <= '0;
         end
         next_id_q   <= '0;
         launch_id_q <= '0;
         rr_q        <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         dp_q        <= dp_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         id_q        <= id_d;
         owner_q     <= owner_d;
         next_id_q   <= next_id_d;
         launch_id_q <= launch_id_d;
         rr_q        <= rr_d;
         error_q     <= error_d;
      end
   end

endmodule

// File: tb/tb_tgroup_scheduler.sv
// tb_tgroup_scheduler
//   Randomized bench for tgroup_scheduler. A transaction-level model keeps the
//   live thread groups in a queue and predicts every output each cycle.
module tb_tgroup_scheduler;

   localparam int unsigned NR    = 2;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PCW   = 16;
   localparam int unsigned AW    = 32;
   localparam int unsigned TBW   = 8;
   localparam int unsigned TGW   = 8;
   localparam int unsigned RIW   = 1;
   localparam int unsigned IDMOD = 1 << TGW;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NR-1:0]       req_valid, req_ready;
   logic [NR*PCW-1:0]   req_pc;
   logic [NR*AW-1:0]    req_dp;
   logic [NR*TBW-1:0]   req_ntb;
   logic [TGW-1:0]      acc_id;
   logic                disp_ready, disp_start;
   logic [PCW-1:0]      disp_pc;
   logic [AW-1:0]       disp_dp;
   logic [TBW-1:0]      disp_ntb;
   logic [TGW-1:0]      disp_id;
   logic                tb_done;
   logic [TGW-1:0]      tb_done_id;
   logic                done_valid, done_ready;
   logic [TGW-1:0]      done_id;
   logic [RIW-1:0]      done_req;
   logic                err;

   always #5 clk = ~clk;

   tgroup_scheduler #(
      .NumRequesters (NR),
      .Depth         (DEPTH),
      .PcWidth       (PCW),
      .AddressWidth  (AW),
      .TblockIdxBits (TBW),
      .TgroupIdBits  (TGW)
   ) dut (
      .clk_i                    (clk),
      .rst_ni                   (rst_n),
      .req_valid_i              (req_valid),
      .req_ready_o              (req_ready),
      .req_pc_i                 (req_pc),
      .req_dp_addr_i            (req_dp),
      .req_number_of_tblocks_i  (req_ntb),
      .accept_tgroup_id_o       (acc_id),
      .disp_ready_i             (disp_ready),
      .disp_start_o             (disp_start),
      .disp_pc_o                (disp_pc),
      .disp_dp_addr_o           (disp_dp),
      .disp_number_of_tblocks_o (disp_ntb),
      .disp_tgroup_id_o         (disp_id),
      .tblock_done_i            (tb_done),
      .tblock_done_tgroup_id_i  (tb_done_id),
      .done_valid_o             (done_valid),
      .done_ready_i             (done_ready),
      .done_tgroup_id_o         (done_id),
      .done_requester_o         (done_req),
      .error_o                  (err)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int unsigned     id;
      int unsigned     req;
      logic [PCW-1:0]  pc;
      logic [AW-1:0]   dp;
      logic [TBW-1:0]  cnt;
      int unsigned     rem;
      bit              running;
   } grp_t;

   grp_t        live[$];
   int unsigned m_next_id, m_launch_id, m_rr;
   bit          m_err;

   function automatic int find_slot(input int unsigned slot);
      foreach (live[k])
         if (live[k].id % DEPTH == slot) return k;
      return -1;
   endfunction

   task automatic model_reset();
      live.delete();
      m_next_id   = 0;
      m_launch_id = 0;
      m_rr        = 0;
      m_err       = 1'b0;
   endtask

   // Compare DUT outputs against the model for the current inputs; with
   // commit set, advance the model as the coming clock edge will.
   task automatic step(input bit commit);
      bit            g_ok;
      int unsigned   g_req, r, best;
      int            li, di, ci;
      logic [NR-1:0] e_ready;
      grp_t          ng;

      g_ok = 1'b0; g_req = 0; e_ready = '0;
      if (find_slot(m_next_id % DEPTH) < 0) begin
         for (int unsigned k = 0; k < NR; k++) begin
            r = (m_rr + k) % NR;
            if (!g_ok && req_valid[r]) begin
               g_ok  = 1'b1;
               g_req = r;
            end
         end
      end
      if (g_ok) e_ready[g_req] = 1'b1;

      li = -1;
      foreach (live[k])
         if (live[k].id == m_launch_id && !live[k].running) li = k;

      di = -1; best = DEPTH;
      foreach (live[k])
         if (live[k].running && live[k].rem == 0 && live[k].id % DEPTH < best) begin
            best = live[k].id % DEPTH;
            di   = k;
         end

      check_val("ready",  req_ready, e_ready);
      check_val("acc_id", acc_id, m_next_id);
      check_val("start",  disp_start, li >= 0);
      check_val("pc",     disp_pc,  (li >= 0) ? live[li].pc  : '0);
      check_val("dp",     disp_dp,  (li >= 0) ? live[li].dp  : '0);
      check_val("ntb",    disp_ntb, (li >= 0) ? live[li].cnt : '0);
      check_val("tgid",   disp_id,  (li >= 0) ? live[li].id  : 0);
      check_val("done_v", done_valid, di >= 0);
      check_val("done_id",  done_id,  (di >= 0) ? live[di].id  : 0);
      check_val("done_req", done_req, (di >= 0) ? live[di].req : 0);
      check_val("err",    err, m_err);

      if (commit) begin
         ci = -1;
         if (tb_done) begin
            ci = find_slot(tb_done_id % DEPTH);
            if (ci < 0 || !live[ci].running || live[ci].rem == 0) begin
               m_err = 1'b1;
               ci    = -1;
            end
         end
         if (ci >= 0) live[ci].rem--;
         if (li >= 0 && disp_ready) begin
            live[li].running = 1'b1;
            m_launch_id = (m_launch_id + 1) % IDMOD;
         end
         if (g_ok) begin
            ng.id      = m_next_id;
            ng.req     = g_req;
            ng.pc      = req_pc[g_req*PCW +: PCW];
            ng.dp      = req_dp[g_req*AW +: AW];
            ng.cnt     = req_ntb[g_req*TBW +: TBW];
            ng.rem     = ng.cnt;
            ng.running = 1'b0;
            live.push_back(ng);
            m_next_id = (m_next_id + 1) % IDMOD;
            m_rr      = (g_req + 1) % NR;
         end
         // Appended entries sit past di, so its index is still valid here.
         if (di >= 0 && done_ready) live.delete(di);
      end
   endtask

   // ---------------- stimulus ----------------
   int unsigned p_req = 50, p_disp = 70, p_dready = 70, p_cpl = 60, p_spur = 0;

   function automatic bit chance(input int unsigned pct);
      return $urandom_range(99, 0) < pct;
   endfunction

   task automatic clear_inputs();
      req_valid = '0; req_pc = '0; req_dp = '0; req_ntb = '0;
      disp_ready = 1'b0; tb_done = 1'b0; tb_done_id = '0; done_ready = 1'b0;
   endtask

   task automatic drive();
      int unsigned cands[$];
      for (int unsigned r = 0; r < NR; r++) begin
         req_valid[r] = chance(p_req);
         req_pc[r*PCW +: PCW] = PCW'($urandom);
         req_dp[r*AW +: AW]   = AW'($urandom);
         req_ntb[r*TBW +: TBW] = TBW'($urandom_range(3, 0));
      end
      disp_ready = chance(p_disp);
      done_ready = chance(p_dready);
      tb_done    = 1'b0;
      tb_done_id = TGW'($urandom);
      if (chance(p_spur)) begin
         tb_done = 1'b1;
      end else if (chance(p_cpl)) begin
         foreach (live[k])
            if (live[k].running && live[k].rem > 0) cands.push_back(live[k].id);
         if (cands.size() > 0) begin
            tb_done    = 1'b1;
            tb_done_id = TGW'(cands[$urandom_range(cands.size() - 1, 0)]);
         end
      end
   endtask

   task automatic run(input int unsigned n);
      repeat (n) begin
         @(negedge clk);
         drive();
         #1;
         step(1'b1);
      end
   endtask

   // Reset held for two cycles; the second one also probes the combinational
   // slot-0 grant with every requester valid.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      #1;
      step(1'b0);
      @(negedge clk);
      req_valid = '1;
      #1;
      step(1'b0);
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      do_reset();

      run(400);

      // Fill the table with no completions or reports, then drain.
      p_req = 100; p_disp = 100; p_cpl = 0; p_dready = 0;
      run(30);
      p_req = 50; p_disp = 70; p_cpl = 60; p_dready = 0;
      run(40);
      p_dready = 70;

      // Long run to wrap the 8-bit group ID.
      p_req = 80; p_disp = 80; p_cpl = 80; p_dready = 80;
      run(3000);

      p_spur = 10;
      run(100);
      p_spur = 0;
      run(50);

      do_reset();
      p_req = 50; p_disp = 70; p_cpl = 60; p_dready = 70;
      run(400);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tgroup_scheduler.md
# tgroup_scheduler

Sits in front of `thread_dispatcher` in the BGPU SoC. It accepts kernel-launch requests from several requesters, arbitrates between them round-robin, assigns each a unique thread-group ID, and launches the groups in ID order through the dispatcher's start/ready interface. It counts per-group thread-block completions from the compute clusters and reports each finished group back with its ID and originating requester.

## Interface
- `NumRequesters`, 2: number of launch requesters; ≥1.
- `Depth`, 4: in-flight group table entries; power of two, ≤ 2^TgroupIdBits.
- `PcWidth`, 16: program-counter width.
- `AddressWidth`, 32: data/parameter address width.
- `TblockIdxBits`, 8: width of the thread-block count.
- `TgroupIdBits`, 8: width of the thread-group ID.
- `ReqIdxBits`: derived, max(1, clog2(NumRequesters)); do not override.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NumRequesters  per-requester launch request.
- `req_ready_o`  out  NumRequesters  one-hot grant; transfer when valid & ready.
- `req_pc_i`  in  NumRequesters×PcWidth  kernel PC per requester.
- `req_dp_addr_i`  in  NumRequesters×AddressWidth  parameter address per requester.
- `req_number_of_tblocks_i`  in  NumRequesters×TblockIdxBits  block count per requester.
- `accept_tgroup_id_o`  out  TgroupIdBits  ID given to the granted requester this cycle.
- `disp_ready_i`  in  1  dispatcher idle (dispatcher `ready_o`).
- `disp_start_o`  out  1  launch valid (to dispatcher `start_i`).
- `disp_pc_o`, `disp_dp_addr_o`, `disp_number_of_tblocks_o`, `disp_tgroup_id_o`  out  PcWidth / AddressWidth / TblockIdxBits / TgroupIdBits  launch payload.
- `tblock_done_i`  in  1  one thread block finished.
- `tblock_done_tgroup_id_i`  in  TgroupIdBits  group of the finished block.
- `done_valid_o`  out  1  a group has fully completed.
- `done_ready_i`  in  1  consumer accepts the completion.
- `done_tgroup_id_o`  out  TgroupIdBits  completed group ID.
- `done_requester_o`  out  ReqIdxBits  requester that launched it.
- `error_o`  out  1  sticky: a completion arrived for a non-RUNNING entry or one with remaining = 0.

## Operation
- Table of `Depth` entries, each with state FREE/PENDING/RUNNING, pc, dp_addr, count, requester, and `remaining` (TblockIdxBits). A group's slot is its ID mod Depth.
- Registers: `next_id_q` (next ID to assign), `launch_id_q` (next ID to launch), `rr_q` (round-robin pointer).
- Accept: if slot[next_id_q] is FREE, grant the first valid requester searching from `rr_q` upward with wrap. On grant: entry → PENDING, store payload, set remaining = count, `next_id_q` += 1 mod 2^TgroupIdBits, `rr_q` = granted + 1 mod NumRequesters. If the slot is not FREE, `req_ready_o` = 0 for all requesters.
- `accept_tgroup_id_o` = `next_id_q` (always driven).
- Launch: `disp_start_o` = slot[launch_id_q] is PENDING. The output does not depend on `disp_ready_i`. Payload comes from that entry. On `disp_start_o & disp_ready_i`: entry → RUNNING and `launch_id_q` += 1.
- Completion: on `tblock_done_i`, for slot[tblock_done_tgroup_id_i mod Depth]:
  - If RUNNING with remaining > 0: remaining −= 1.
  - Otherwise: no state change and `error_o` is set.
- Report: `done_valid_o` = some entry is RUNNING with remaining = 0. The lowest slot index is selected. On `done_ready_i` that entry → FREE.
- A count of 0 is legal. The group is launched, the dispatcher issues nothing, and the group becomes reportable once RUNNING.

## Timing
- Reset values:
  - All entries FREE; `next_id_q`, `launch_id_q`, `rr_q` = 0.
  - Outputs: `req_ready_o` = 0 (combinational: reads 1 on the slot-0 grant when valid), `disp_start_o` = 0, `done_valid_o` = 0, `error_o` = 0. All payload outputs are 0 while no entry is selected.
- Reset mid-operation discards every entry and counter. No completion report is produced for discarded groups.
- Latency:
  - Accept at cycle T → `disp_start_o` no earlier than T+1.
  - Last block done at T → `done_valid_o` at T+1.
  - Free at done handshake T → slot acceptable at T+1.
- The state of a given slot is updated from registered values only. Acceptance into a slot being freed in the same cycle is not allowed.
- Same-cycle accept, launch, completion and report on different slots all take effect.
- At most one grant, one launch and one report per cycle.
- IDs wrap from 2^TgroupIdBits−1 to 0.

## Test plan
- Single request: requester 0, count 3, dispatcher ready → ID 0 granted, start 1 cycle later, 3 completions → done ID 0, requester 0.
- Both requesters valid continuously, counts 1 → grants alternate 0,1,0,1; IDs 0,1,2,3 launched in order.
- Fill table: Depth = 4, no completions → 4 accepts, 5th stalled (`req_ready_o` = 0) until ID 0 is reported; then ID 4 is accepted into slot 0.
- Out-of-order completion: IDs 0 and 1 running, ID 1 finishes first → done reports ID 1, then ID 0; `done_ready_i` held low keeps `done_valid_o` asserted.
- Count 0 request → launched, done reported 1 cycle after the start handshake.
- Spurious `tblock_done_i` for a FREE slot → `error_o` rises and stays set; no other state changes; async reset clears all.
